usb_nrzi_rx_decoder: RTL and testbench

Receive-side line decoder directly downstream of the host speed detector. It consumes the one-sample-per-bit D+/D- pair plus the detector's J/K encodings and bus-reset flag. It finds SYNC, NRZI-decodes, removes stuffed bits, detects EOP, and delivers LSB-first bytes with packet framing and error flags to the packet layer.

---
 rtl/usb_nrzi_rx_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_usb_nrzi_rx_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_nrzi_rx_decoder.sv
// ============================================================================
// Module   : usb_nrzi_rx_decoder
// Purpose  : USB receive line decoder: SYNC hunt, NRZI decode, bit unstuffing,
//            EOP detection and LSB-first byte assembly with packet framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_nrzi_rx_decoder #(
    parameter int STUFF_LIMIT = 6,
    parameter int SYNC_ZEROS  = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] usb_signals,
    input  logic [1:0] j_state,
    input  logic [1:0] k_state,
    input  logic       bus_reset,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_active
);

    localparam logic [3:0] STUFF_MAX = 4'(STUFF_LIMIT);
    localparam logic [3:0] SYNC_MAX  = 4'(SYNC_ZEROS);

    typedef enum logic [1:0] {
        CL_J   = 2'd0,
        CL_K   = 2'd1,
        CL_SE0 = 2'd2,
        CL_SE1 = 2'd3
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP      = 3'd3,
        ST_ERR_WAIT = 3'd4
    } state_t;

    state_t     state;
    line_t      prev;
    line_t      line_cls;
    logic [3:0] zero_cnt;
    logic [3:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [1:0] se0_cnt;
    logic       j_cnt;
    logic       first_byte;
    logic [7:0] shreg;
    logic       dec_bit;
    logic       cfg_bad;
    logic [7:0] shift_next;

    always_comb begin
        line_cls = CL_SE1;
        if (usb_signals == j_state)      line_cls = CL_J;
        else if (usb_signals == k_state) line_cls = CL_K;
        else if (usb_signals == 2'b00)   line_cls = CL_SE0;
        else                             line_cls = CL_SE1;
    end

    assign cfg_bad    = (j_state == k_state);
    assign dec_bit    = (line_cls == prev);
    assign shift_next = {dec_bit, shreg[7:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            prev       <= CL_J;
            zero_cnt   <= 4'd0;
            ones_cnt   <= 4'd0;
            bit_cnt    <= 3'd0;
            se0_cnt    <= 2'd0;
            j_cnt      <= 1'b0;
            first_byte <= 1'b0;
            shreg      <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_error   <= 1'b0;
            rx_active  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
            prev     <= line_cls;
            if (bus_reset || cfg_bad) begin
                // Bus reset and an unconfigured detector both park the decoder.
                state      <= ST_IDLE;
                prev       <= CL_J;
                zero_cnt   <= 4'd0;
                ones_cnt   <= 4'd0;
                bit_cnt    <= 3'd0;
                se0_cnt    <= 2'd0;
                j_cnt      <= 1'b0;
                first_byte <= 1'b0;
                rx_data    <= 8'h00;
                rx_active  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        prev <= CL_J;
                        if (line_cls == CL_K) begin
                            state    <= ST_SYNC;
                            prev     <= CL_K;
                            zero_cnt <= 4'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (line_cls == CL_SE0) begin
                            state <= ST_IDLE;
                            prev  <= CL_J;
                        end else if (line_cls == CL_SE1 ||
                                     (!dec_bit && zero_cnt == SYNC_MAX) ||
                                     (dec_bit && zero_cnt != SYNC_MAX)) begin
                            state    <= ST_ERR_WAIT;
                            rx_error <= 1'b1;
                            j_cnt    <= 1'b0;
                        end else if (!dec_bit) begin
                            zero_cnt <= zero_cnt + 4'd1;
                        end else begin
                            // The closing 1 of SYNC starts the stuffing run.
                            state      <= ST_DATA;
                            rx_active  <= 1'b1;
                            ones_cnt   <= 4'd1;
                            bit_cnt    <= 3'd0;
                            first_byte <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (line_cls == CL_SE0) begin
                            state   <= ST_EOP;
                            se0_cnt <= 2'd1;
                        end else if (line_cls == CL_SE1 ||
                                     (ones_cnt == STUFF_MAX && dec_bit)) begin
                            state     <= ST_ERR_WAIT;
                            rx_error  <= 1'b1;
                            rx_active <= 1'b0;
                            j_cnt     <= 1'b0;
                        end else if (ones_cnt == STUFF_MAX) begin
                            ones_cnt <= 4'd0;
                        end else begin
                            shreg    <= shift_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            ones_cnt <= dec_bit ? ones_cnt + 4'd1 : 4'd0;
                            if (bit_cnt == 3'd7) begin
                                rx_data    <= shift_next;
                                rx_valid   <= 1'b1;
                                rx_sop     <= first_byte;
                                first_byte <= 1'b0;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (line_cls == CL_SE0) begin
                            if (se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
                        end else if (line_cls == CL_J && se0_cnt >= 2'd2) begin
                            state     <= ST_IDLE;
                            prev      <= CL_J;
                            rx_eop    <= 1'b1;
                            rx_error  <= (bit_cnt != 3'd0);
                            rx_active <= 1'b0;
                        end else begin
                            state     <= ST_ERR_WAIT;
                            rx_error  <= 1'b1;
                            rx_active <= 1'b0;
                            j_cnt     <= 1'b0;
                        end
                    end
                    ST_ERR_WAIT: begin
                        rx_active <= 1'b0;
                        if (line_cls == CL_J) begin
                            if (j_cnt) begin
                                state <= ST_IDLE;
                                prev  <= CL_J;
                                j_cnt <= 1'b0;
                            end else begin
                                j_cnt <= 1'b1;
                            end
                        end else begin
                            j_cnt <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        prev  <= CL_J;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_nrzi_rx_decoder.sv
// ============================================================================
// Module   : tb_usb_nrzi_rx_decoder
// Purpose  : Directed self-checking bench for usb_nrzi_rx_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_nrzi_rx_decoder;

    logic       clock;
    logic       reset_n;
    logic [1:0] usb_signals;
    logic [1:0] j_state;
    logic [1:0] k_state;
    logic       bus_reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_error;
    logic       rx_active;

    int checks;
    int errors;

    // Per-section event log, filled while samples are driven.
    logic [7:0] bytes_q[$];
    logic       sop_q[$];
    int         valid_at[$];
    int         sample_idx;
    int         n_eop;
    int         n_err;
    int         n_active;

    usb_nrzi_rx_decoder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .usb_signals (usb_signals),
        .j_state     (j_state),
        .k_state     (k_state),
        .bus_reset   (bus_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_error    (rx_error),
        .rx_active   (rx_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] code(input byte c);
        case (c)
            "J":     return 2'b10;
            "K":     return 2'b01;
            "0":     return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    task automatic clear_log();
        bytes_q.delete();
        sop_q.delete();
        valid_at.delete();
        sample_idx = 0;
        n_eop      = 0;
        n_err      = 0;
        n_active   = 0;
    endtask

    task automatic drive(input logic [1:0] v);
        usb_signals = v;
        @(posedge clock);
        #1;
        sample_idx++;
        if (rx_valid) begin
            bytes_q.push_back(rx_data);
            sop_q.push_back(rx_sop);
            valid_at.push_back(sample_idx);
        end
        if (rx_eop)    n_eop++;
        if (rx_error)  n_err++;
        if (rx_active) n_active++;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) drive(code(s[i]));
    endtask

    task automatic sync_seq();
        send("JKJKJKJKK");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus_reset   = 1'b0;
        j_state     = 2'b10;
        k_state     = 2'b01;
        usb_signals = 2'b10;
        clear_log();

        // Reset state
        #1;
        check("reset_data",   rx_data,   8'h00);
        check("reset_active", rx_active, 1'b0);
        check("reset_strobe", {rx_valid, rx_sop, rx_eop, rx_error}, 4'b0000);
        repeat (2) @(posedge clock);
        #4 reset_n = 1'b1;

        // Packet 0xA5 with legal EOP
        send("JJ");
        send("KJKJKJK");
        check("sync_active_early", rx_active, 1'b0);
        send("K");
        check("sync_active_rise", rx_active, 1'b1);
        clear_log();
        send("KJJKJJKK");
        check("a5_count", bytes_q.size(), 1);
        check("a5_data",  bytes_q.size() > 0 ? bytes_q[0] : 8'hxx, 8'hA5);
        check("a5_sop",   sop_q.size() > 0 ? sop_q[0] : 1'bx, 1'b1);
        check("a5_when",  valid_at.size() > 0 ? valid_at[0] : -1, 8);
        send("00");
        check("a5_eop_early", rx_eop, 1'b0);
        send("J");
        check("a5_eop",    rx_eop,    1'b1);
        check("a5_err",    rx_error,  1'b0);
        check("a5_active", rx_active, 1'b0);

        // 0xFF 0x01 with a stuffed bit inside the first byte
        send("J");
        sync_seq();
        clear_log();
        send("KKKKKJJJJJKJKJKJK");
        check("stuff_count", bytes_q.size(), 2);
        check("stuff_b0",    bytes_q.size() > 0 ? bytes_q[0] : 8'hxx, 8'hFF);
        check("stuff_sop0",  sop_q.size() > 0 ? sop_q[0] : 1'bx, 1'b1);
        check("stuff_t0",    valid_at.size() > 0 ? valid_at[0] : -1, 9);
        check("stuff_b1",    bytes_q.size() > 1 ? bytes_q[1] : 8'hxx, 8'h01);
        check("stuff_sop1",  sop_q.size() > 1 ? sop_q[1] : 1'bx, 1'b0);
        check("stuff_t1",    valid_at.size() > 1 ? valid_at[1] : -1, 17);
        send("00J");
        check("stuff_eop",   n_eop, 1);
        check("stuff_noerr", n_err, 0);

        // Stuff violation: six data 1s after SYNC
        send("J");
        sync_seq();
        clear_log();
        send("KKKKK");
        check("viol_pre_err", rx_error, 1'b0);
        send("K");
        check("viol_err",    rx_error,  1'b1);
        check("viol_active", rx_active, 1'b0);
        send("KJJ");
        check("viol_no_eop", n_eop, 0);
        check("viol_one_err", n_err, 1);

        // 12 data bits then legal EOP: partial-byte error alongside EOP
        sync_seq();
        clear_log();
        send("JKJKJKJKJKJK");
        check("part_count", bytes_q.size(), 1);
        check("part_data",  bytes_q.size() > 0 ? bytes_q[0] : 8'hxx, 8'h00);
        send("00J");
        check("part_eop", rx_eop,   1'b1);
        check("part_err", rx_error, 1'b1);

        // bus_reset mid-packet, then a fresh packet
        send("J");
        sync_seq();
        send("KJJ");
        bus_reset = 1'b1;
        drive(code("K"));
        bus_reset = 1'b0;
        check("busrst_active", rx_active, 1'b0);
        check("busrst_strobe", {rx_valid, rx_sop, rx_eop, rx_error}, 4'b0000);
        send("J");
        sync_seq();
        clear_log();
        send("KJJKJJKK00J");
        check("after_rst_data", bytes_q.size() > 0 ? bytes_q[0] : 8'hxx, 8'hA5);
        check("after_rst_sop",  sop_q.size() > 0 ? sop_q[0] : 1'bx, 1'b1);
        check("after_rst_eop",  n_eop, 1);
        check("after_rst_err",  n_err, 0);

        // Asynchronous reset mid-byte
        send("J");
        sync_seq();
        send("KJJ");
        #2 reset_n = 1'b0;
        #1;
        check("async_active", rx_active, 1'b0);
        check("async_data",   rx_data,   8'h00);
        #3 reset_n = 1'b1;
        k_state = 2'b10;
        clear_log();
        send("JKJKJKJKKKJJKJJKK00J");
        check("nocfg_valid",  bytes_q.size(), 0);
        check("nocfg_eop",    n_eop, 0);
        check("nocfg_err",    n_err, 0);
        check("nocfg_active", n_active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
